// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side controller.
package fifo_pkg;

    // Write controller FSM encoding
    typedef enum logic {
        SEND  = 1'b0,
        STALL = 1'b1
    } wr_state_e;

    // Default data word width; must match the FIFO's BUS_SIZE
    localparam int unsigned FIFO_BUS_SIZE_DEFAULT = 5;

    // Bit n set means a skid buffer depth of n entries is legal (2 or 4)
    localparam logic [7:0] SKID_DEPTH_LEGAL_MASK = 8'b0001_0100;

    function automatic bit skid_depth_legal(input int unsigned depth);
        return (depth < 8) && SKID_DEPTH_LEGAL_MASK[depth[2:0]];
    endfunction

endpackage

// File: rtl/fifo_writer_skid.sv
// Circular skid buffer between the upstream source and the FIFO push register.
// ready is decoded from the registered occupancy only.
module fifo_writer_skid
    import fifo_pkg::*;
#(
    parameter int unsigned BUS_SIZE   = FIFO_BUS_SIZE_DEFAULT,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [BUS_SIZE-1:0] wr_data,
    input  logic                rd_en,
    output logic [BUS_SIZE-1:0] rd_data,
    output logic                has_data,
    output logic                ready
);

    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
    localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SKID_DEPTH);

    logic [BUS_SIZE-1:0] mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    // Occupancy update; simultaneous write and read leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally at SKID_DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array; contents are only observed while occupied
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign has_data = (count_q != '0);
    assign ready    = (count_q < FULL);

endmodule

// File: rtl/fifo_writer.sv
// Write-side controller for the flow-controlled FIFO: skid buffer, SEND/STALL
// FSM with pause/continua hysteresis, and the registered push/data_out stage.
// Optional macro FIFO_WRITER_STATS_EN adds saturating push_cnt/stall_cnt outputs.
module fifo_writer
    import fifo_pkg::*;
#(
    parameter int unsigned BUS_SIZE   = FIFO_BUS_SIZE_DEFAULT,
    parameter int unsigned SKID_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src_valid,
    input  logic [BUS_SIZE-1:0]  src_data,
    output logic                 src_ready,
    input  logic                 pause,
    input  logic                 continua,
    input  logic                 empty,
    output logic                 push,
    output logic [BUS_SIZE-1:0]  data_out,
    output logic                 valid_out,
    output logic                 drained
`ifdef FIFO_WRITER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] push_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    if (!skid_depth_legal(SKID_DEPTH) || CNT_WIDTH == 0) begin : g_bad_cfg
        $error("fifo_writer: SKID_DEPTH must be 2 or 4 and CNT_WIDTH nonzero");
    end

    wr_state_e           state_q, state_d;
    logic                push_en;
    logic                accept;
    logic                has_data;
    logic [BUS_SIZE-1:0] rd_data;
    logic                push_q;
    logic [BUS_SIZE-1:0] data_q;
    logic                drained_q;

    assign accept = src_valid && src_ready;

    fifo_writer_skid #(
        .BUS_SIZE   (BUS_SIZE),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_data  (src_data),
        .rd_en    (push_en),
        .rd_data  (rd_data),
        .has_data (has_data),
        .ready    (src_ready)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= SEND;
        else       state_q <= state_d;
    end

    // FSM next state: pause enters STALL, continua without pause leaves it
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEND:    if (pause)                state_d = STALL;
            STALL:   if (continua && !pause)   state_d = SEND;
            default: state_d = SEND;
        endcase
    end

    // FSM output: pop a word when sending, not paused this cycle, and occupied
    always_comb begin
        push_en = (state_q == SEND) && !pause && has_data;
    end

    // Push register stage; data_out holds its last value between pushes
    always_ff @(posedge clk) begin
        if (reset) begin
            push_q    <= 1'b0;
            data_q    <= '0;
            drained_q <= 1'b0;
        end else begin
            push_q    <= push_en;
            if (push_en) data_q <= rd_data;
            drained_q <= !has_data && empty && !push_q;
        end
    end

    assign push      = push_q;
    assign valid_out = push_q;
    assign data_out  = data_q;
    assign drained   = drained_q;

`ifdef FIFO_WRITER_STATS_EN
    logic [CNT_WIDTH-1:0] push_cnt_q, stall_cnt_q;

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            push_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push_en && push_cnt_q != '1)
                push_cnt_q <= push_cnt_q + 1'b1;
            if (state_q == STALL && has_data && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign push_cnt  = push_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_writer.sv
// Self-checking bench for fifo_writer (SKID_DEPTH=2, BUS_SIZE=5).
module tb_fifo_writer;

    localparam int unsigned W     = 5;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         src_valid = 1'b0;
    logic [W-1:0] src_data = '0;
    logic         src_ready;
    logic         pause = 1'b0;
    logic         continua = 1'b0;
    logic         empty = 1'b1;
    logic         push;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         drained;
`ifdef FIFO_WRITER_STATS_EN
    logic [CW-1:0] push_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_writer #(
        .BUS_SIZE   (W),
        .SKID_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .pause     (pause),
        .continua  (continua),
        .empty     (empty),
        .push      (push),
        .data_out  (data_out),
        .valid_out (valid_out),
        .drained   (drained)
`ifdef FIFO_WRITER_STATS_EN
        ,
        .push_cnt  (push_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: a word queue plus a stalled flag
    logic [W-1:0] m_q[$];
    bit           m_stall   = 0;
    bit           m_push    = 0;
    logic [W-1:0] m_data    = '0;
    bit           m_drained = 0;
    bit           known     = 0;
    int unsigned  m_pc = 0, m_sc = 0;
    int unsigned  sat = (1 << CW) - 1;

    task automatic tick();
        int  sz;
        bit  pop;
        @(posedge clk);
        sz = m_q.size();
        if (rst) begin
            m_q.delete();
            m_stall = 0; m_push = 0; m_data = '0; m_drained = 0;
            m_pc = 0; m_sc = 0; known = 1;
        end else begin
            pop       = !m_stall && !pause && sz > 0;
            m_drained = (sz == 0) && empty && !m_push;
            if (pop && m_pc < sat) m_pc++;
            if (m_stall && sz > 0 && m_sc < sat) m_sc++;
            if (pop) m_data = m_q.pop_front();
            m_push = pop;
            if (src_valid && sz < DEPTH) m_q.push_back(src_data);
            if (!m_stall && pause)                   m_stall = 1;
            else if (m_stall && continua && !pause)  m_stall = 0;
        end
        #1;
        if (known) begin
            check("m_push",    push,      m_push);
            check("m_valid",   valid_out, m_push);
            check("m_data",    data_out,  m_data);
            check("m_drained", drained,   m_drained);
            check("m_ready",   src_ready, m_q.size() < DEPTH);
`ifdef FIFO_WRITER_STATS_EN
            check("m_push_cnt",  push_cnt,  m_pc);
            check("m_stall_cnt", stall_cnt, m_sc);
`endif
        end
    endtask

    typedef struct {
        bit           rst, sv;
        logic [W-1:0] sd;
        bit           pa, co, em;
        bit           e_push;
        logic [W-1:0] e_data;
        bit           e_ready, e_drained;
    } vec_t;

    function automatic vec_t mk(bit r, bit v, logic [W-1:0] d, bit p, bit c, bit e,
                                bit ep, logic [W-1:0] ed, bit er, bit edr);
        vec_t x;
        x.rst = r; x.sv = v; x.sd = d; x.pa = p; x.co = c; x.em = e;
        x.e_push = ep; x.e_data = ed; x.e_ready = er; x.e_drained = edr;
        return x;
    endfunction

    vec_t         vq[$];
    logic [W-1:0] got[$];
    int           idx;
    bit           acc;

    initial begin
        // rst  sv  sd    pa co em | push data  rdy drained
        vq.push_back(mk(1, 0, 5'h00, 0, 0, 1,  0, 5'h00, 1, 0));  // reset
        vq.push_back(mk(0, 1, 5'h01, 0, 0, 1,  0, 5'h00, 1, 1));
        vq.push_back(mk(0, 1, 5'h02, 0, 0, 1,  1, 5'h01, 1, 0));
        vq.push_back(mk(0, 1, 5'h03, 0, 0, 1,  1, 5'h02, 1, 0));
        vq.push_back(mk(0, 1, 5'h04, 0, 0, 1,  1, 5'h03, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  1, 5'h04, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  0, 5'h04, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  0, 5'h04, 1, 1));
        // pause while three words offered: only two accepted
        vq.push_back(mk(0, 1, 5'h0A, 1, 0, 1,  0, 5'h04, 1, 1));
        vq.push_back(mk(0, 1, 5'h0B, 1, 0, 1,  0, 5'h04, 0, 0));
        vq.push_back(mk(0, 1, 5'h0C, 1, 0, 1,  0, 5'h04, 0, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 1, 1,  0, 5'h04, 0, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  1, 5'h0A, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  1, 5'h0B, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  0, 5'h0B, 1, 0));
        // pause and continua together keep STALL
        vq.push_back(mk(0, 1, 5'h11, 1, 0, 1,  0, 5'h0B, 1, 1));
        vq.push_back(mk(0, 0, 5'h00, 1, 1, 1,  0, 5'h0B, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 1, 1,  0, 5'h0B, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  1, 5'h11, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  0, 5'h11, 1, 0));
        // reset with two words buffered discards them
        vq.push_back(mk(0, 1, 5'h15, 1, 0, 1,  0, 5'h11, 1, 1));
        vq.push_back(mk(0, 1, 5'h16, 1, 0, 1,  0, 5'h11, 0, 0));
        vq.push_back(mk(1, 1, 5'h17, 0, 0, 1,  0, 5'h00, 1, 0));
        vq.push_back(mk(0, 1, 5'h18, 0, 0, 1,  0, 5'h00, 1, 1));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  1, 5'h18, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  0, 5'h18, 1, 0));
        vq.push_back(mk(0, 0, 5'h00, 0, 0, 1,  0, 5'h18, 1, 1));

        foreach (vq[i]) begin
            rst = vq[i].rst; src_valid = vq[i].sv; src_data = vq[i].sd;
            pause = vq[i].pa; continua = vq[i].co; empty = vq[i].em;
            tick();
            check($sformatf("v%0d_push", i),    push,      vq[i].e_push);
            check($sformatf("v%0d_valid", i),   valid_out, vq[i].e_push);
            check($sformatf("v%0d_data", i),    data_out,  vq[i].e_data);
            check($sformatf("v%0d_ready", i),   src_ready, vq[i].e_ready);
            check($sformatf("v%0d_drained", i), drained,   vq[i].e_drained);
        end

        // Streaming 0..9 with simultaneous accept and pop; pointers wrap
        rst = 1; src_valid = 0; pause = 0; continua = 0; empty = 1;
        tick();
        rst = 0;
        idx = 0;
        for (int cyc = 0; cyc < 40 && got.size() < 10; cyc++) begin
            src_valid = (idx < 10);
            src_data  = W'(idx);
            acc = src_valid && src_ready;
            tick();
            if (acc) idx++;
            if (push) got.push_back(data_out);
        end
        src_valid = 0;
        check("stream_count", got.size(), 10);
        foreach (got[i]) check($sformatf("stream_word%0d", i), got[i], i);

        // Randomised traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            src_valid = ($urandom_range(0, 3) != 0);
            src_data  = W'($urandom);
            pause     = ($urandom_range(0, 4) == 0);
            continua  = ($urandom_range(0, 2) == 0);
            empty     = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
